// File: rtl/accum_pkg.sv
// Shared types and default sizes for the accumulate sequencer and its adder.
package accum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } accum_state_t;

  localparam int ACC_N     = 8;
  localparam int ACC_COUNT = 4;

endpackage

// File: rtl/accum_seq_if.sv
// Operand handshake, register feedback/control and status signals of accum_seq.
// valid/ready: a beat transfers on a rising clk edge where in_valid & in_ready;
// in_data must be stable while in_valid is high, and in_ready never depends on in_valid.
interface accum_seq_if
  import accum_pkg::*;
#(
  parameter int N = ACC_N
);
  logic         start;
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic [N-1:0] reg_q;
  logic [N-1:0] reg_in;
  logic         reg_load;
  logic         reg_clear;
  logic         busy;
  logic         done;
  logic         ovf;

  modport slave (
    input  start, in_valid, in_data, reg_q,
    output in_ready, reg_in, reg_load, reg_clear, busy, done, ovf
  );

  modport master (
    output start, in_valid, in_data, reg_q,
    input  in_ready, reg_in, reg_load, reg_clear, busy, done, ovf
  );
endinterface

// File: rtl/accum_add.sv
// N+1-bit add of the register value and an operand; saturates to all ones on
// carry when ACCUM_SAT_EN is defined, otherwise wraps modulo 2^N.
module accum_add
  import accum_pkg::*;
#(
  parameter int N = ACC_N
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] sum_o,
  output logic         carry_o
);

  logic [N:0] raw;

  assign raw     = {1'b0, a_i} + {1'b0, b_i};
  assign carry_o = raw[N];

`ifdef ACCUM_SAT_EN
  assign sum_o = raw[N] ? {N{1'b1}} : raw[N-1:0];
`else
  assign sum_o = raw[N-1:0];
`endif

endmodule

// File: rtl/accum_seq.sv
// Batch sequencer driving a downstream load/clear register so it ends up holding
// the sum of COUNT operands. Saturating add is selected with ACCUM_SAT_EN.
module accum_seq
  import accum_pkg::*;
#(
  parameter int N     = ACC_N,
  parameter int COUNT = ACC_COUNT
) (
  input  logic              clk,
  input  logic              clear_n,
  accum_seq_if.slave        bus,
  output accum_state_t      state_dbg_o
);

  localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  accum_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          accept;
  logic [N-1:0]  add_sum;
  logic          add_carry;

  accum_add #(.N(N)) u_add (
    .a_i     (bus.reg_q),
    .b_i     (bus.in_data),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = CLR;
      end
      CLR: begin
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = ACC;
      end
      ACC: begin
        if (bus.in_valid) begin
          accept = 1'b1;
          cnt_d  = cnt_q + CW'(1);
          ovf_d  = ovf_q | add_carry;
          if (cnt_q == LAST) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // reg_in is gated by the load so it reads zero whenever no beat is taken,
  // including while reset holds the FSM in IDLE.
  assign bus.in_ready  = (state_q == ACC);
  assign bus.reg_load  = accept;
  assign bus.reg_in    = accept ? add_sum : '0;
  assign bus.reg_clear = (state_q == CLR);
  assign bus.busy      = (state_q == CLR) || (state_q == ACC);
  assign bus.done      = (state_q == DONE);
  assign bus.ovf       = ovf_q;
  assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_accum_seq.sv
// Self-checking bench for accum_seq with a behavioral load/clear register downstream.
module tb_accum_seq;
  import accum_pkg::*;

  localparam int N     = 8;
  localparam int COUNT = 4;

  logic         clk = 1'b0;
  logic         clear_n = 1'b0;
  logic [N-1:0] rq;
  accum_state_t state_dbg;

  accum_seq_if #(.N(N)) bus ();

  accum_seq #(.N(N), .COUNT(COUNT)) dut (
    .clk         (clk),
    .clear_n     (clear_n),
    .bus         (bus),
    .state_dbg_o (state_dbg)
  );

  // ---------------- clock / reset / environment ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  assign bus.reg_q = rq;
  always @(posedge clk) begin
    if (bus.reg_clear)     rq <= '0;
    else if (bus.reg_load) rq <= bus.reg_in;
  end

  // ---------------- scoreboard ----------------
  logic [N-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int start_cyc = 0;
  logic [N-1:0] model_sum;

  function automatic logic [N:0] model_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] w;
    w = {1'b0, a} + {1'b0, b};
`ifdef ACCUM_SAT_EN
    if (w[N]) w[N-1:0] = {N{1'b1}};
`endif
    return w;
  endfunction

  always @(negedge clk) begin
    if (bus.reg_load) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL reg_in_unexpected: load with reg_in=%0d, required no load", bus.reg_in);
      end else begin
        logic [N-1:0] e;
        e = exp_q.pop_front();
        if (bus.reg_in !== e) $display("FAIL reg_in: got %0d required %0d (cycle %0d)", bus.reg_in, e, cyc);
        else n_pass++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_batch();
    start_cyc = cyc;
    bus.start = 1'b1;
    next_cycle();
    bus.start = 1'b0;
    model_sum = '0;
  endtask

  task automatic drive_beat(input logic [N-1:0] d);
    logic [N:0] r;
    bool_wait: begin end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    r = model_add(model_sum, d);
    model_sum = r[N-1:0];
    exp_q.push_back(r[N-1:0]);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      if (i == 39) begin
        n_checks++;
        $display("FAIL beat_timeout: in_ready stayed 0, required 1 within 40 cycles");
      end
      next_cycle();
    end
    next_cycle();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = cyc - start_cyc;
        break;
      end
      next_cycle();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_n = 1'b0;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.in_ready, bus.reg_load, bus.reg_clear, bus.busy, bus.done, bus.ovf} !== 6'b0)
      $display("FAIL reset_flags: got %b required 000000",
               {bus.in_ready, bus.reg_load, bus.reg_clear, bus.busy, bus.done, bus.ovf});
    else n_pass++;
    n_checks++;
    if (bus.reg_in !== '0) $display("FAIL reset_reg_in: got %0d required 0", bus.reg_in);
    else n_pass++;
    n_checks++;
    if (state_dbg !== IDLE) $display("FAIL reset_state: got %0d required %0d", state_dbg, IDLE);
    else n_pass++;
    next_cycle();
    clear_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_basic();
    int lat;
    start_batch();
    @(negedge clk);
    n_checks++;
    if ({bus.reg_clear, bus.busy, bus.in_ready} !== 3'b110)
      $display("FAIL clr_cycle: got clear/busy/ready=%b required 110", {bus.reg_clear, bus.busy, bus.in_ready});
    else n_pass++;
    next_cycle();
    for (int i = 1; i <= 4; i++) drive_beat(N'(i));
    wait_done(lat);
    n_checks++;
    if (lat !== COUNT + 2) $display("FAIL basic_latency: got %0d required %0d", lat, COUNT + 2);
    else n_pass++;
    n_checks++;
    if (rq !== 8'h0A) $display("FAIL basic_sum: got %0h required 0a", rq);
    else n_pass++;
    n_checks++;
    if ({bus.ovf, bus.in_ready, bus.busy} !== 3'b000)
      $display("FAIL basic_done_flags: got ovf/ready/busy=%b required 000", {bus.ovf, bus.in_ready, bus.busy});
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0 || state_dbg !== IDLE)
      $display("FAIL basic_after_done: got done=%b state=%0d required done=0 state=%0d", bus.done, state_dbg, IDLE);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_stall();
    int lat;
    start_batch();
    next_cycle();
    for (int b = 0; b < 4; b++) begin
      drive_beat(8'd5);
      if (b < 3) begin
        for (int g = 0; g < 2; g++) begin
          @(negedge clk);
          n_checks++;
          if (bus.reg_load !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL stall_gap: got load=%b ready=%b required load=0 ready=1", bus.reg_load, bus.in_ready);
          else n_pass++;
          next_cycle();
        end
      end
    end
    wait_done(lat);
    n_checks++;
    if (lat !== COUNT + 2 + 6) $display("FAIL stall_latency: got %0d required %0d", lat, COUNT + 8);
    else n_pass++;
    n_checks++;
    if (rq !== 8'h14) $display("FAIL stall_sum: got %0h required 14", rq);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_overflow_sticky();
    int lat;
    logic [N-1:0] exp_final;
`ifdef ACCUM_SAT_EN
    exp_final = 8'd255;
`else
    exp_final = 8'd49;
`endif
    start_batch();
    next_cycle();
    drive_beat(8'd200);
    drive_beat(8'd100);
    drive_beat(8'd0);
    drive_beat(8'd5);
    wait_done(lat);
    n_checks++;
    if (rq !== exp_final || bus.ovf !== 1'b1)
      $display("FAIL ovf_batch: got sum=%0d ovf=%b required sum=%0d ovf=1", rq, bus.ovf, exp_final);
    else n_pass++;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.ovf !== 1'b1 || bus.busy !== 1'b0)
        $display("FAIL ovf_hold_idle: got ovf=%b busy=%b required ovf=1 busy=0", bus.ovf, bus.busy);
      else n_pass++;
      next_cycle();
    end
    start_batch();
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (bus.ovf !== 1'b0) $display("FAIL ovf_cleared: got %b required 0", bus.ovf);
    else n_pass++;
    next_cycle();
    drive_beat(8'd3);
    drive_beat(8'd0);
    drive_beat(8'd0);
    drive_beat(8'd0);
    wait_done(lat);
    n_checks++;
    if (lat !== COUNT + 3 || rq !== 8'd3 || bus.ovf !== 1'b0)
      $display("FAIL ovf_next_batch: got lat=%0d sum=%0d ovf=%b required lat=%0d sum=3 ovf=0",
               lat, rq, bus.ovf, COUNT + 3);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_ignored_inputs();
    int lat;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.reg_load !== 1'b0)
        $display("FAIL idle_valid: got ready=%b load=%b required 0 0", bus.in_ready, bus.reg_load);
      else n_pass++;
      next_cycle();
    end
    bus.in_valid = 1'b0;
    start_batch();
    next_cycle();
    drive_beat(8'd2);
    drive_beat(8'd2);
    bus.start = 1'b1;
    drive_beat(8'd3);
    bus.start = 1'b0;
    drive_beat(8'd4);
    wait_done(lat);
    n_checks++;
    if (lat !== COUNT + 2 || rq !== 8'd11)
      $display("FAIL start_in_acc: got lat=%0d sum=%0d required lat=%0d sum=11", lat, rq, COUNT + 2);
    else n_pass++;
    bus.start = 1'b1;
    next_cycle();
    bus.start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (state_dbg !== IDLE || bus.reg_clear !== 1'b0)
      $display("FAIL start_in_done: got state=%0d clear=%b required state=%0d clear=0", state_dbg, bus.reg_clear, IDLE);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_reset_mid_batch();
    int lat;
    start_batch();
    next_cycle();
    drive_beat(8'd9);
    drive_beat(8'd9);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd9;
    #2;
    clear_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.in_ready, bus.reg_load, bus.reg_clear, bus.busy, bus.done, bus.ovf} !== 6'b0 || bus.reg_in !== '0)
      $display("FAIL reset_mid: got flags=%b reg_in=%0d required 000000 and 0",
               {bus.in_ready, bus.reg_load, bus.reg_clear, bus.busy, bus.done, bus.ovf}, bus.reg_in);
    else n_pass++;
    bus.in_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || state_dbg !== IDLE)
      $display("FAIL reset_mid_hold: got busy=%b state=%0d required busy=0 state=%0d", bus.busy, state_dbg, IDLE);
    else n_pass++;
    next_cycle();
    clear_n = 1'b1;
    next_cycle();
    start_batch();
    next_cycle();
    for (int i = 0; i < 4; i++) drive_beat(8'd1);
    wait_done(lat);
    n_checks++;
    if (lat !== COUNT + 2 || rq !== 8'd4)
      $display("FAIL after_reset_batch: got lat=%0d sum=%0d required lat=%0d sum=4", lat, rq, COUNT + 2);
    else n_pass++;
    next_cycle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    model_sum = '0;
    test_reset();
    test_basic();
    test_stall();
    test_overflow_sticky();
    test_ignored_inputs();
    test_reset_mid_batch();
    repeat (2) next_cycle();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL beats_outstanding: got %0d required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
